// File: rtl/mp_addsub_iter.sv
// Multi-precision adder/subtractor that processes one CHUNK-bit slice per clock.
// Operands are captured on start; the carry ripples between cycles through a single flop.
module mp_addsub_iter #(
    parameter int unsigned WIDTH = 1027,
    parameter int unsigned CHUNK = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             done,
    output logic             busy
);

    localparam int unsigned NCHUNK = (WIDTH + CHUNK) / CHUNK;
    localparam int unsigned PADW   = NCHUNK * CHUNK;
    localparam int unsigned SUMW   = (NCHUNK - 1) * CHUNK;
    localparam int unsigned TOPW   = WIDTH + 1 - SUMW;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [PADW-1:0]   a_q, a_d;
    logic [PADW-1:0]   b_q, b_d;
    logic [SUMW-1:0]   sum_q, sum_d;
    logic [TOPW-1:0]   top_q, top_d;
    logic              done_q, done_d;
    logic [CHUNK:0]    add_c;

    // One chunk of the addition: low slices of the shifting operands plus the saved carry.
    always_comb begin
        add_c = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            top_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            top_q   <= top_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: capture on start, then consume one chunk per cycle.
    // Low chunks shift into sum_q from the top; the final chunk lands in top_q,
    // which leaves the full result right-aligned without a wide index mux.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        top_d   = top_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = PADW'(in_a);
                    b_d     = PADW'(in_b) ^ {PADW{subtract}};
                    cnt_d   = '0;
                    carry_d = subtract;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = add_c[CHUNK];
                a_d     = {{CHUNK{1'b0}}, a_q[PADW-1:CHUNK]};
                b_d     = {{CHUNK{1'b0}}, b_q[PADW-1:CHUNK]};
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    top_d   = add_c[TOPW-1:0];
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    sum_d = {add_c[CHUNK-1:0], sum_q[SUMW-1:CHUNK]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = {top_q, sum_q};
    assign done   = done_q;
    assign busy   = (state_q == RUN);

endmodule

// File: doc/mp_addsub_iter.md
MP_ADDSUB_ITER -- requirements
Module: mp_addsub_iter

Interface
REQ-001 Parameter WIDTH, default 1027: operand width in bits.
REQ-002 Parameter CHUNK, default 64: bits added per cycle; NCHUNK = ceil((WIDTH+1)/CHUNK), 17 at defaults.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request; sampled only while idle.
REQ-006 subtract  input  1  0 = add, 1 = subtract; captured with start.
REQ-007 in_a  input  WIDTH  operand A; captured with start.
REQ-008 in_b  input  WIDTH  operand B; captured with start.
REQ-009 result  output  WIDTH+1  sum or difference.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high while an operation is in flight.

Function
REQ-012 The block SHALL use a two-state FSM: IDLE and RUN.
REQ-013 In IDLE, start=1 at a rising edge SHALL capture in_a, in_b and subtract into internal registers zero-padded to NCHUNK*CHUNK bits, set the chunk counter to 0, preset the carry to subtract, and enter RUN.
REQ-014 In RUN, each edge SHALL add chunk i of A, chunk i of (B XOR {subtract}), and the carry; it SHALL write CHUNK sum bits into the internal sum register, register the carry-out and increment the counter.
REQ-015 When the counter reaches NCHUNK-1 on an edge, that edge SHALL write the last chunk, return to IDLE and assert done.
REQ-016 done SHALL be high for exactly one cycle per accepted start; there are NCHUNK edges from the accept edge to the done edge, 17 at defaults.
REQ-017 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-018 Add: result SHALL equal A + B with the carry in bit WIDTH.
REQ-019 Subtract: result SHALL equal (A - B) mod 2^(WIDTH+1); bit WIDTH is 1 iff A < B.
REQ-020 result SHALL equal bits [WIDTH:0] of the internal sum register and is valid from the done cycle until the next accept edge; it SHALL NOT be sampled while busy.
REQ-021 start asserted while busy SHALL be ignored and SHALL NOT be queued; a caller holding start high gets back-to-back operations.
REQ-022 start high during the done cycle SHALL be accepted on the next edge, because the FSM is already in IDLE.
REQ-023 in_a, in_b and subtract SHALL be don't-care except on the accept edge; changing them mid-operation SHALL NOT affect result.
REQ-024 The carry between chunks SHALL be the only inter-cycle arithmetic dependency; no combinational path spans more than CHUNK+1 bits of carry.

Reset
REQ-025 While resetn=0 at an edge: FSM SHALL go to IDLE, counter and carry to 0, sum register to 0, done=0, busy=0, result=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL behave normally.
REQ-027 start high during reset SHALL be ignored; it is sampled from the first edge with resetn=1.

Verification
REQ-028 Add of 1 + 1 -> done on edge 17 after accept, result=2, busy high for 17 cycles.
REQ-029 Add of (2^1027-1) + 1 -> result bit 1027=1, all others 0 (carry ripples through all chunks).
REQ-030 Subtract 5 - 7 -> result = 2^1028 - 2 (bit 1027=1); subtract 7 - 5 -> result=2, bit 1027=0.
REQ-031 start pulsed at accept+3 with new operands -> ignored; first result correct, exactly one done.
REQ-032 start held high continuously -> done pulses 18 cycles apart; each result matches its captured operands.
REQ-033 resetn low at accept+8, released 2 cycles later -> no done, outputs 0; the next 1 + 1 gives result=2.
